usb_fifo_buffer: RTL and testbench
==================================

Name: usb_fifo_buffer

Overview:
- Parametrised circular-buffer data FIFO for the USB endpoint datapath, replacing the shift-register byte buffer.
- Shared between the TX path (host-side store, packet-side get) and the RX path (packet-side store, host-side get).
- Uses read/write pointers into a DEPTH x DATA_W array and reports exact occupancy, full and empty.
- Flags overflow and underflow; sits between the protocol FSMs and the AHB-side data registers.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 64, number of entries; power of two, minimum 4
AF_MARGIN, 4, almost-full/almost-empty margin in entries (used only with the optional feature)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
Store_TX_Data  in  1  push TX_Data
Store_RX_Packet_Data  in  1  push RX_Packet_Data
TX_Data  in  DATA_W  TX write data
RX_Packet_Data  in  DATA_W  RX write data
Get_TX_Packet_Data  in  1  pop to TX_Packet_Data
Get_RX_Data  in  1  pop to RX_Data
flush  in  1  discard all contents
clear  in  1  discard all contents (same effect as flush)
TX_Packet_Data  out  DATA_W  registered TX pop data
RX_Data  out  DATA_W  registered RX pop data
Buffer_Occupancy  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
full  out  1  Buffer_Occupancy == DEPTH
empty  out  1  Buffer_Occupancy == 0
overflow  out  1  one-cycle pulse: push rejected
underflow  out  1  one-cycle pulse: pop rejected

Behaviour:
- Reset (async, n_rst low):
  - Pointers, occupancy, TX_Packet_Data, RX_Data, overflow and underflow all go to 0; empty=1, full=0.
  - Array contents are not reset.
- Push select: Store_TX_Data has priority over Store_RX_Packet_Data; at most one push per cycle.
- Pop select: Get_TX_Packet_Data has priority over Get_RX_Data; at most one pop per cycle.
- Push accepted iff (not full) or (full and a pop is accepted in the same cycle).
  - On acceptance: write to mem[wptr]; wptr increments modulo DEPTH.
- Pop accepted iff not empty; there is no bypass, so a push to an empty FIFO cannot be popped in the same cycle.
  - On acceptance: rptr increments modulo DEPTH.
  - The selected output register loads mem[rptr] at that edge, so data is valid the cycle after the Get strobe (latency 1).
  - The non-selected output register loads 0.
- Any cycle without an accepted pop: both output registers load 0, so each output is a one-cycle data strobe.
- Occupancy update:
  - +1 on push only; -1 on pop only.
  - Unchanged when both a push and a pop are accepted.
  - Never wraps past DEPTH or below 0.
- Rejected push (full, no accepted pop): data dropped, nothing changes, overflow=1 for one cycle.
- Rejected pop (empty): output loads 0, underflow=1 for one cycle.
- Simultaneous push and pop:
  - When empty: push accepted, pop rejected with underflow; occupancy becomes 1.
  - When full: both accepted; the popped word is the old mem[rptr].
- flush or clear (highest priority):
  - Next edge: pointers and occupancy go to 0; outputs go to 0.
  - Same-cycle Store/Get strobes are ignored; no overflow/underflow pulse.
- full and empty are combinational decodes of the registered occupancy.
- Pointers are $clog2(DEPTH) bits wide; wrap-around is natural binary rollover.

Optional Feature:
- Macro USB_BUFFER_WATERMARK_EN.
- Defined: adds outputs almost_full (Buffer_Occupancy >= DEPTH-AF_MARGIN) and almost_empty (Buffer_Occupancy <= AF_MARGIN), both combinational from registered occupancy.
- Undefined: those ports and that logic are absent; AF_MARGIN is ignored.

Decomposition:
- Package usb_buffer_pkg holds:
  - default DATA_W/DEPTH constants
  - an occupancy-width function (clog2(DEPTH)+1)
  - a typedef for push/pop source select (SRC_NONE, SRC_TX, SRC_RX)
- Sub-module usb_buffer_ptr: wrap-around pointer register with enable and synchronous clear, instantiated for rptr and wptr.
- The occupancy counter stays inline.

Test Plan:
- Reset, then push 0x11..0x14 via Store_TX_Data, then 4 Get_TX_Packet_Data -> TX_Packet_Data = 0x11,0x12,0x13,0x14 on successive cycles after each Get; occupancy 4->0; empty=1.
- Push 64 words with RX_Packet_Data = index (0x00..0x3F) -> full=1, occupancy=64; 65th push -> overflow pulse, occupancy stays 64; 64 Get_RX_Data -> RX_Data = 0x00..0x3F.
- Wrap-around: push 40, pop 40, push 40, pop 40 (values 0x80+i) -> order preserved across the pointer wrap; occupancy returns to 0.
- Full with simultaneous Store_TX_Data(0xAA) + Get_TX_Packet_Data -> oldest word popped, 0xAA accepted, occupancy stays 64, no overflow. Empty with simultaneous push 0x55 + Get -> underflow=1, output 0, occupancy=1.
- Occupancy 10, assert flush together with Store_TX_Data -> next cycle occupancy=0, empty=1, no overflow; a following Get -> underflow pulse.
- Assert n_rst low mid-stream at occupancy 7 -> immediately occupancy=0 and outputs 0. With USB_BUFFER_WATERMARK_EN, occupancy 60 -> almost_full=1; occupancy 4 -> almost_empty=1.

Source files
------------

// File: rtl/usb_buffer_pkg.sv
// Shared constants and types for the USB endpoint circular-buffer FIFO.
package usb_buffer_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 64;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_TX   = 2'd1,
        SRC_RX   = 2'd2
    } src_sel_e;

    // Occupancy must represent 0..DEPTH inclusive, hence one bit more than a pointer.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/usb_buffer_ptr.sv
// Wrap-around FIFO pointer with increment enable and synchronous clear.
module usb_buffer_ptr #(
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (en)
            ptr <= ptr + PTR_W'(1);
    end

endmodule

// File: rtl/usb_fifo_buffer.sv
// Circular-buffer data FIFO shared by the USB TX and RX endpoint paths.
// Optional watermark outputs are enabled with macro USB_BUFFER_WATERMARK_EN.
module usb_fifo_buffer
    import usb_buffer_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_MARGIN = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          Store_TX_Data,
    input  logic                          Store_RX_Packet_Data,
    input  logic [DATA_W-1:0]             TX_Data,
    input  logic [DATA_W-1:0]             RX_Packet_Data,
    input  logic                          Get_TX_Packet_Data,
    input  logic                          Get_RX_Data,
    input  logic                          flush,
    input  logic                          clear,
    output logic [DATA_W-1:0]             TX_Packet_Data,
    output logic [DATA_W-1:0]             RX_Data,
    output logic [occ_width(DEPTH)-1:0]   Buffer_Occupancy,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    output logic                          underflow
`ifdef USB_BUFFER_WATERMARK_EN
    ,
    output logic                          almost_full,
    output logic                          almost_empty
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);
    localparam bit PARAMS_OK = (DEPTH >= 4) && ((DEPTH & (DEPTH - 1)) == 0)
                               && (AF_MARGIN >= 0) && (AF_MARGIN < DEPTH);

    if (!PARAMS_OK) begin : g_param_error
        $error("usb_fifo_buffer: DEPTH must be a power of two >= 4 and AF_MARGIN < DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  wptr;
    src_sel_e          push_src;
    src_sel_e          pop_src;
    logic [DATA_W-1:0] push_data;
    logic              flush_any;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (Buffer_Occupancy == OCC_W'(DEPTH));
    assign empty = (Buffer_Occupancy == '0);

`ifdef USB_BUFFER_WATERMARK_EN
    assign almost_full  = (Buffer_Occupancy >= OCC_W'(DEPTH - AF_MARGIN));
    assign almost_empty = (Buffer_Occupancy <= OCC_W'(AF_MARGIN));
`endif

    always_comb begin
        push_src  = SRC_NONE;
        pop_src   = SRC_NONE;
        push_data = RX_Packet_Data;
        flush_any = flush | clear;

        if (Store_TX_Data) begin
            push_src  = SRC_TX;
            push_data = TX_Data;
        end else if (Store_RX_Packet_Data) begin
            push_src  = SRC_RX;
        end

        if (Get_TX_Packet_Data)
            pop_src = SRC_TX;
        else if (Get_RX_Data)
            pop_src = SRC_RX;

        // No bypass: a pop only ever sees data already held, so a full FIFO can
        // accept a push exactly when a word leaves in the same cycle.
        pop_ok  = (pop_src != SRC_NONE) && !empty && !flush_any;
        push_ok = (push_src != SRC_NONE) && (!full || pop_ok) && !flush_any;
    end

    usb_buffer_ptr #(.PTR_W(PTR_W)) u_wptr (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (push_ok),
        .clr   (flush_any),
        .ptr   (wptr)
    );

    usb_buffer_ptr #(.PTR_W(PTR_W)) u_rptr (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (pop_ok),
        .clr   (flush_any),
        .ptr   (rptr)
    );

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= push_data;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            Buffer_Occupancy <= '0;
            TX_Packet_Data   <= '0;
            RX_Data          <= '0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
        end else begin
            if (flush_any)
                Buffer_Occupancy <= '0;
            else if (push_ok && !pop_ok)
                Buffer_Occupancy <= Buffer_Occupancy + OCC_W'(1);
            else if (pop_ok && !push_ok)
                Buffer_Occupancy <= Buffer_Occupancy - OCC_W'(1);

            // Output registers act as one-cycle data strobes.
            TX_Packet_Data <= (pop_ok && pop_src == SRC_TX) ? mem[rptr] : '0;
            RX_Data        <= (pop_ok && pop_src == SRC_RX) ? mem[rptr] : '0;
            overflow       <= (push_src != SRC_NONE) && !push_ok && !flush_any;
            underflow      <= (pop_src != SRC_NONE) && !pop_ok && !flush_any;
        end
    end

endmodule

// File: tb/tb_usb_fifo_buffer.sv
// Directed self-checking bench for usb_fifo_buffer (DEPTH=64, DATA_W=8).
module tb_usb_fifo_buffer;

    logic       clk;
    logic       n_rst;
    logic       store_tx, store_rx, get_tx, get_rx, flush, clear;
    logic [7:0] tx_data, rx_pkt_data;
    logic [7:0] tx_pkt, rx_out;
    logic [6:0] occ;
    logic       full, empty, overflow, underflow;
`ifdef USB_BUFFER_WATERMARK_EN
    logic       almost_full, almost_empty;
`endif

    int checks = 0;
    int errors = 0;

    usb_fifo_buffer #(.DATA_W(8), .DEPTH(64), .AF_MARGIN(4)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .Store_TX_Data        (store_tx),
        .Store_RX_Packet_Data (store_rx),
        .TX_Data              (tx_data),
        .RX_Packet_Data       (rx_pkt_data),
        .Get_TX_Packet_Data   (get_tx),
        .Get_RX_Data          (get_rx),
        .flush                (flush),
        .clear                (clear),
        .TX_Packet_Data       (tx_pkt),
        .RX_Data              (rx_out),
        .Buffer_Occupancy     (occ),
        .full                 (full),
        .empty                (empty),
        .overflow             (overflow),
        .underflow            (underflow)
`ifdef USB_BUFFER_WATERMARK_EN
        ,
        .almost_full          (almost_full),
        .almost_empty         (almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       stx;
        logic       srx;
        logic [7:0] txd;
        logic [7:0] rxd;
        logic       gtx;
        logic       grx;
        logic       fl;
        logic       cl;
        logic [7:0] exp_tx;
        logic [7:0] exp_rx;
        int         exp_occ;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic stx, input logic srx, input logic [7:0] txd,
                          input logic [7:0] rxd, input logic gtx, input logic grx,
                          input logic fl, input logic cl);
        store_tx = stx; store_rx = srx; tx_data = txd; rx_pkt_data = rxd;
        get_tx = gtx; get_rx = grx; flush = fl; clear = cl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    endtask

    initial begin
        vecs[0]  = '{1,0,8'h11,8'h00, 0,0,0,0, 8'h00,8'h00, 1, 0,0};
        vecs[1]  = '{1,0,8'h12,8'h00, 0,0,0,0, 8'h00,8'h00, 2, 0,0};
        vecs[2]  = '{1,0,8'h13,8'h00, 0,0,0,0, 8'h00,8'h00, 3, 0,0};
        vecs[3]  = '{1,1,8'h14,8'h99, 0,0,0,0, 8'h00,8'h00, 4, 0,0};
        vecs[4]  = '{0,0,8'h00,8'h00, 1,0,0,0, 8'h11,8'h00, 3, 0,0};
        vecs[5]  = '{0,0,8'h00,8'h00, 1,1,0,0, 8'h12,8'h00, 2, 0,0};
        vecs[6]  = '{0,0,8'h00,8'h00, 0,1,0,0, 8'h00,8'h13, 1, 0,0};
        vecs[7]  = '{0,0,8'h00,8'h00, 1,0,0,0, 8'h14,8'h00, 0, 0,0};
        vecs[8]  = '{0,0,8'h00,8'h00, 0,0,0,0, 8'h00,8'h00, 0, 0,0};
        vecs[9]  = '{0,0,8'h00,8'h00, 0,1,0,0, 8'h00,8'h00, 0, 0,1};
        vecs[10] = '{1,0,8'h55,8'h00, 1,0,0,0, 8'h00,8'h00, 1, 0,1};
        vecs[11] = '{0,0,8'h00,8'h00, 0,1,0,0, 8'h00,8'h55, 0, 0,0};
        vecs[12] = '{1,0,8'h77,8'h00, 1,0,0,1, 8'h00,8'h00, 0, 0,0};

        n_rst = 1'b0;
        idle();
        #12;
        chk("reset_occ", 32'(occ), 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_full", 32'(full), 0);
        chk("reset_outs", {tx_pkt, rx_out, 6'd0, overflow, underflow}, 0);
        n_rst = 1'b1;
        tick();

        for (int v = 0; v < 13; v++) begin
            set_in(vecs[v].stx, vecs[v].srx, vecs[v].txd, vecs[v].rxd,
                   vecs[v].gtx, vecs[v].grx, vecs[v].fl, vecs[v].cl);
            tick();
            chk($sformatf("vec%0d_tx", v), 32'(tx_pkt), 32'(vecs[v].exp_tx));
            chk($sformatf("vec%0d_rx", v), 32'(rx_out), 32'(vecs[v].exp_rx));
            chk($sformatf("vec%0d_occ", v), 32'(occ), 32'(vecs[v].exp_occ));
            chk($sformatf("vec%0d_empty", v), 32'(empty), 32'(vecs[v].exp_occ == 0));
            chk($sformatf("vec%0d_ovf", v), 32'(overflow), 32'(vecs[v].exp_ovf));
            chk($sformatf("vec%0d_unf", v), 32'(underflow), 32'(vecs[v].exp_unf));
        end
        idle();
        tick();

        // Fill to full, overflow on the 65th push, then drain on the RX side.
        for (int i = 0; i < 64; i++) begin
            set_in(0, 1, 8'h00, 8'(i), 0, 0, 0, 0);
            tick();
        end
        chk("fill_occ", 32'(occ), 64);
        chk("fill_full", 32'(full), 1);
        set_in(0, 1, 8'h00, 8'hEE, 0, 0, 0, 0);
        tick();
        chk("ovf_pulse", 32'(overflow), 1);
        chk("ovf_occ", 32'(occ), 64);
        idle();
        tick();
        chk("ovf_clear", 32'(overflow), 0);
        for (int i = 0; i < 64; i++) begin
            set_in(0, 0, 8'h00, 8'h00, 0, 1, 0, 0);
            tick();
            chk($sformatf("drain_rx%0d", i), 32'(rx_out), 32'(i));
        end
        idle();
        tick();
        chk("drain_occ", 32'(occ), 0);
        chk("drain_empty", 32'(empty), 1);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 64; i++) begin
            set_in(1, 0, 8'(8'h40 + i), 8'h00, 0, 0, 0, 0);
            tick();
        end
        set_in(1, 0, 8'hAA, 8'h00, 1, 0, 0, 0);
        tick();
        chk("fullpp_tx", 32'(tx_pkt), 32'h40);
        chk("fullpp_occ", 32'(occ), 64);
        chk("fullpp_ovf", 32'(overflow), 0);
        chk("fullpp_full", 32'(full), 1);
        for (int i = 0; i < 64; i++) begin
            set_in(0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
            tick();
            chk($sformatf("fullpp_drain%0d", i), 32'(tx_pkt), (i < 63) ? 32'(8'h41 + i) : 32'hAA);
        end
        idle();
        tick();
        chk("fullpp_empty", 32'(empty), 1);

        // Two push/pop rounds of 40 force both pointers across the wrap.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 40; i++) begin
                set_in(0, 1, 8'h00, 8'(8'h80 + i), 0, 0, 0, 0);
                tick();
            end
            chk($sformatf("wrap%0d_occ", r), 32'(occ), 40);
            for (int i = 0; i < 40; i++) begin
                set_in(0, 0, 8'h00, 8'h00, 0, 1, 0, 0);
                tick();
                chk($sformatf("wrap%0d_rx%0d", r, i), 32'(rx_out), 32'(8'h80 + i));
            end
        end
        idle();
        tick();
        chk("wrap_occ", 32'(occ), 0);

        // Flush wins over a same-cycle store.
        for (int i = 0; i < 10; i++) begin
            set_in(1, 0, 8'(i), 8'h00, 0, 0, 0, 0);
            tick();
        end
        chk("preflush_occ", 32'(occ), 10);
        set_in(1, 0, 8'h33, 8'h00, 0, 0, 1, 0);
        tick();
        chk("flush_occ", 32'(occ), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_ovf", 32'(overflow), 0);
        set_in(0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        tick();
        chk("postflush_unf", 32'(underflow), 1);
        chk("postflush_tx", 32'(tx_pkt), 0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 8; i++) begin
            set_in(1, 0, 8'(8'h60 + i), 8'h00, 0, 0, 0, 0);
            tick();
        end
        set_in(0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        tick();
        chk("prerst_tx", 32'(tx_pkt), 32'h60);
        chk("prerst_occ", 32'(occ), 7);
        idle();
        #2 n_rst = 1'b0;
        #1;
        chk("arst_occ", 32'(occ), 0);
        chk("arst_tx", 32'(tx_pkt), 0);
        chk("arst_empty", 32'(empty), 1);
        #2 n_rst = 1'b1;
        tick();

`ifdef USB_BUFFER_WATERMARK_EN
        for (int i = 0; i < 59; i++) begin
            set_in(1, 0, 8'(i), 8'h00, 0, 0, 0, 0);
            tick();
        end
        chk("af_59", 32'(almost_full), 0);
        set_in(1, 0, 8'h3B, 8'h00, 0, 0, 0, 0);
        tick();
        chk("af_60", 32'(almost_full), 1);
        chk("ae_60", 32'(almost_empty), 0);
        for (int i = 0; i < 55; i++) begin
            set_in(0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
            tick();
        end
        chk("ae_5", 32'(almost_empty), 0);
        set_in(0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        tick();
        chk("ae_4", 32'(almost_empty), 1);
        chk("ae_occ", 32'(occ), 4);
        idle();
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
